// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL reconfiguration controller: FSM state
// encodings, default timing constants, the divider-code bundle and helpers.
package pll_ctrl_pkg;

  // Default timing, in clkin cycles (clkin is the 50 MHz PLL reference)
  localparam int DEF_RESET_CYCLES  = 16;
  localparam int DEF_STABLE_CYCLES = 8;
  localparam int DEF_LOCK_TIMEOUT  = 50000;

  // FSM state encodings
  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  // Raw divider codes driven onto the PLLVR IDSEL/FBDSEL/ODSEL pins
  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } div_codes_t;

  // Counter width able to hold 0 .. n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  // 8-bit increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into clk_i domain.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is ever consumed downstream
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration controller: pulses PLL RESET, waits for a stable LOCK
// with a timeout, reports lock/loss/timeout status and accepts new divider
// codes only while running or after a failed lock attempt.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int         RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int         STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int         LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter logic [5:0] INIT_IDSEL    = 6'd0,
  parameter logic [5:0] INIT_FBDSEL   = 6'd0,
  parameter logic [5:0] INIT_ODSEL    = 6'd0
) (
  input  logic       clkin,
  input  logic       rstn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idsel,
  input  logic [5:0] req_fbdsel,
  input  logic [5:0] req_odsel,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  input  logic       lock_i,
  output logic       locked,
  output logic       err_timeout,
  output logic       lock_lost,
  output logic [7:0] relock_cnt
);

  localparam int RW = cnt_width(RESET_CYCLES);
  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam int TW = cnt_width(LOCK_TIMEOUT);

  // Terminal counts: each counter stops one short of its parameter
  localparam logic [RW-1:0] RST_LAST    = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);

  localparam div_codes_t INIT_CODES = '{idsel: INIT_IDSEL, fbdsel: INIT_FBDSEL, odsel: INIT_ODSEL};

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  div_codes_t    codes_q, codes_d;
  logic          lock_lost_q, lock_lost_d;
  logic [7:0]    relock_cnt_q, relock_cnt_d;
  logic          pll_reset_q, locked_q, req_ready_q, err_timeout_q;

  logic       lock_sync_s;
  logic       accept_s;
  logic       lock_done_s;
  div_codes_t req_codes_s;

  sync_2ff u_lock_sync (
    .clk_i  (clkin),
    .rst_ni (rstn),
    .d_i    (lock_i),
    .q_o    (lock_sync_s)
  );

  assign accept_s    = req_valid && req_ready_q;
  assign req_codes_s = '{idsel: req_idsel, fbdsel: req_fbdsel, odsel: req_odsel};
  // The stable-lock run completes on this edge
  assign lock_done_s = lock_sync_s && (stable_cnt_q == STABLE_LAST);

  // Next-state logic: sequencing, counters, code latch and loss bookkeeping
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    stable_cnt_d = stable_cnt_q;
    to_cnt_d     = to_cnt_q;
    codes_d      = codes_q;
    lock_lost_d  = lock_lost_q;
    relock_cnt_d = relock_cnt_q;

    case (state_q)
      ST_RST: begin
        stable_cnt_d = '0;
        to_cnt_d     = '0;
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ST_WAIT;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      ST_WAIT: begin
        // Any synced-low cycle restarts the stable run
        if (lock_sync_s && !lock_done_s) begin
          stable_cnt_d = stable_cnt_q + SW'(1);
        end else begin
          stable_cnt_d = '0;
        end
        // A lock completing on the timeout edge still counts as a lock
        if (lock_done_s) begin
          state_d = ST_RUN;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_FAIL;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      ST_RUN: begin
        // An accepted request outranks a coincident lock drop
        if (accept_s) begin
          state_d     = ST_RST;
          rst_cnt_d   = '0;
          codes_d     = req_codes_s;
          lock_lost_d = 1'b0;
        end else if (!lock_sync_s) begin
          state_d      = ST_RST;
          rst_cnt_d    = '0;
          lock_lost_d  = 1'b1;
          relock_cnt_d = sat_inc8(relock_cnt_q);
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FAIL: begin
        if (accept_s) begin
          state_d     = ST_RST;
          rst_cnt_d   = '0;
          codes_d     = req_codes_s;
          lock_lost_d = 1'b0;
        end else begin
          state_d = ST_FAIL;
        end
      end

      default: begin
        state_d   = ST_RST;
        rst_cnt_d = '0;
      end
    endcase
  end

  // State, counters and registered outputs (decoded from the next state)
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_RST;
      rst_cnt_q     <= '0;
      stable_cnt_q  <= '0;
      to_cnt_q      <= '0;
      codes_q       <= INIT_CODES;
      lock_lost_q   <= 1'b0;
      relock_cnt_q  <= 8'd0;
      pll_reset_q   <= 1'b1;
      locked_q      <= 1'b0;
      req_ready_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      to_cnt_q      <= to_cnt_d;
      codes_q       <= codes_d;
      lock_lost_q   <= lock_lost_d;
      relock_cnt_q  <= relock_cnt_d;
      pll_reset_q   <= (state_d == ST_RST);
      locked_q      <= (state_d == ST_RUN);
      req_ready_q   <= (state_d == ST_RUN) || (state_d == ST_FAIL);
      err_timeout_q <= (state_d == ST_FAIL);
    end
  end

  assign pll_reset   = pll_reset_q;
  assign locked      = locked_q;
  assign req_ready   = req_ready_q;
  assign err_timeout = err_timeout_q;
  assign lock_lost   = lock_lost_q;
  assign relock_cnt  = relock_cnt_q;
  assign idsel       = codes_q.idsel;
  assign fbdsel      = codes_q.fbdsel;
  assign odsel       = codes_q.odsel;

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: PLL RESET pulse width in clkin cycles (>=2).
REQ-002 SHALL have parameter STABLE_CYCLES, default 8: consecutive synchronized LOCK-high cycles required to declare lock (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 50000: maximum clkin cycles from RESET release to declared lock (1 ms at 50 MHz).
REQ-004 SHALL have parameters INIT_IDSEL, INIT_FBDSEL, INIT_ODSEL, each 6 bits, default 6'd0: divider codes applied at power-up.
REQ-005 clkin  in  1  single clock, 50 MHz PLL reference; all logic on rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  reconfiguration request.
REQ-008 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-009 req_idsel, req_fbdsel, req_odsel  in  6 each  requested raw divider codes.
REQ-010 pll_reset  out  1  drives PLLVR RESET (active high).
REQ-011 idsel, fbdsel, odsel  out  6 each  drive PLLVR IDSEL/FBDSEL/ODSEL.
REQ-012 lock_i  in  1  PLLVR LOCK, asynchronous to clkin.
REQ-013 locked  out  1  PLL declared locked and codes stable.
REQ-014 err_timeout  out  1  last lock attempt timed out.
REQ-015 lock_lost  out  1  sticky: lock dropped while in RUN.
REQ-016 relock_cnt  out  8  saturating count of lock-loss events.

Function
REQ-017 SHALL synchronize lock_i through a 2-flop synchronizer; only the synchronized value is used.
REQ-018 SHALL implement states RST, WAIT, RUN, FAIL.
REQ-019 RST: pll_reset=1 for exactly RESET_CYCLES cycles, then go to WAIT.
REQ-020 WAIT: pll_reset=0; stable counter increments while synced lock=1 and clears on 0; on reaching STABLE_CYCLES go to RUN.
REQ-021 WAIT: timeout counter counts from entry; on reaching LOCK_TIMEOUT without lock go to FAIL.
REQ-022 RUN: locked=1, req_ready=1; synced lock=0 sets lock_lost, increments relock_cnt (saturate at 255), go to RST with unchanged codes.
REQ-023 FAIL: err_timeout=1, pll_reset=0, req_ready=1; remains until a request is accepted.
REQ-024 req_ready SHALL be 0 in RST and WAIT; requests there are ignored (held off, not queued).
REQ-025 On acceptance, codes are latched into idsel/fbdsel/odsel on the same edge, locked and err_timeout clear, state goes to RST.
REQ-026 Simultaneous accepted request and lock drop in RUN: request wins; lock_lost and relock_cnt unchanged.
REQ-027 Divider outputs SHALL change only on request acceptance, never during WAIT.
REQ-028 lock_lost SHALL clear only on accepted request or reset.
REQ-029 Counters SHALL be sized by $clog2 of their parameter; no wrap before terminal value.

Reset
REQ-030 On rstn low: state=RST, pll_reset=1, codes=INIT_*, locked=0, req_ready=0, err_timeout=0, lock_lost=0, relock_cnt=0, counters and synchronizer cleared.
REQ-031 On rstn release: full RST/WAIT power-up sequence executes with INIT codes.
REQ-032 Reset asserted mid-sequence SHALL abort immediately; no partial state survives.

Structure
REQ-033 State enum and default timing constants SHALL reside in shared package pll_ctrl_pkg.
REQ-034 The 2-flop synchronizer SHALL be a sub-module named sync_2ff.

Verification
REQ-035 Release rstn, lock_i rises 40 cycles later -> pll_reset high cycles 0-15, locked=1 after 2+8 cycles of lock.
REQ-036 In RUN, request idsel=3, fbdsel=10, odsel=8 -> codes update same edge, pll_reset high 16 cycles, locked returns.
REQ-037 lock_i held 0 -> err_timeout=1 exactly 50000 cycles after RESET release; later request clears it.
REQ-038 In RUN drop lock_i 3 cycles -> lock_lost=1, relock_cnt=1, RST re-entered, codes unchanged.
REQ-039 Lock glitches shorter than 8 cycles in WAIT -> stable counter restarts; locked stays 0.
REQ-040 Request coincident with synced lock drop -> request honoured, relock_cnt unchanged; rstn pulse mid-WAIT -> INIT codes restored.
